demux_feed_stage: RTL and testbench
===================================

Name: demux_feed_stage

Overview:
- Pipeline buffer stage that sits directly upstream of the 1-to-2 result demux in the 8-bit pipeline processor.
- Accepts ALU/writeback results, each tagged with a one-bit route select, through a valid/ready handshake.
- Queues them in a small in-order FIFO and presents the head entry as the demux data and select, so back-pressure from the consumer never drops a result.
- When empty it drives zero data and select 0, so both demux outputs read zero on idle cycles.

Parameters:
- WIDTH, 8, data width of each result and of demux_in.
- DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset: synchronous, active-high.
- flush  input  1  synchronous clear of all queued entries (pipeline flush).
- in_valid  input  1  upstream result valid.
- in_ready  output  1  stage can accept a result this cycle.
- in_data  input  WIDTH  result value.
- in_sel  input  1  route select (1 = data_out1 path, 0 = data_out2 path).
- out_valid  output  1  head entry presented on demux_in/demux_s0 is valid.
- out_ready  input  1  consumer accepts the head entry this cycle.
- demux_in  output  WIDTH  head data to the demux; 0 when out_valid = 0.
- demux_s0  output  1  head select to the demux; 0 when out_valid = 0.
- count  output  $clog2(DEPTH)+1  number of entries held.

Behaviour:
- Storage:
  - DEPTH x (WIDTH+1) array holding {sel, data}.
  - Write pointer and read pointer, each $clog2(DEPTH) bits, wrapping modulo DEPTH.
  - Registered count, range 0..DEPTH.
- Status states (derived from count, registered):
  - EMPTY (count = 0), PARTIAL (0 < count < DEPTH), FULL (count = DEPTH).
  - EMPTY->PARTIAL on push without pop.
  - PARTIAL->FULL on push without pop when count = DEPTH-1.
  - FULL->PARTIAL on pop.
  - PARTIAL->EMPTY on pop without push when count = 1.
  - Any state -> EMPTY on rst or flush.
  - DEPTH = 2 is legal: PARTIAL is then count = 1 only.
- Handshake:
  - in_ready = (state != FULL) and not in reset-hold.
  - push = in_valid & in_ready.
  - out_valid = (state != EMPTY).
  - pop = out_valid & out_ready.
  - in_valid may stay high while in_ready = 0; the stage captures data only on push cycles.
- Push writes {in_sel, in_data} at the write pointer, then increments it. Pop increments the read pointer.
- Count update:
  - count += 1 on push only.
  - count -= 1 on pop only.
  - Unchanged on simultaneous push and pop, which is legal in PARTIAL.
  - In FULL, in_ready = 0, so no push; pop alone applies. There is no same-cycle passthrough from full.
  - In EMPTY, pop is impossible. A push makes out_valid = 1 on the next cycle, giving 1-cycle latency from push to presentation.
- Outputs:
  - demux_in and demux_s0 are the head entry gated by out_valid (zero when EMPTY).
  - Both are stable while out_valid = 1 and out_ready = 0.
- Ordering: strict FIFO; select bits travel with their data.
- Reset (rst = 1 at a clock edge):
  - Pointers, count and state clear; the array contents are not cleared.
  - Reset values: count = 0, out_valid = 0, demux_in = 0, demux_s0 = 0, in_ready = 0 while rst is high.
  - in_ready = 1 on the first cycle after rst deasserts.
  - A reset mid-stream discards all entries; any push or pop in the reset cycle is ignored.
- Flush:
  - Same clearing as reset but in_ready stays 1.
  - flush has priority over a push/pop in the same cycle: that push is discarded and count = 0 next cycle.
- rst has priority over flush.

Test Plan:
- Reset then push {sel=1, 0xA5} with out_ready=0 -> next cycle out_valid=1, demux_in=0xA5, demux_s0=1, count=1; idle before push shows demux_in=0x00, demux_s0=0.
- Push 0x11, 0x22, 0x33, 0x44 (sel 0,1,0,1) with out_ready=0 -> count=4, in_ready=0, a fifth push of 0x55 is not captured; then hold out_ready=1 -> pops 0x11/0, 0x22/1, 0x33/0, 0x44/1 in order, then out_valid=0.
- At count=2, push and pop in the same cycle for 10 cycles (incrementing data) -> count stays 2, output order is preserved, and the pointers wrap past DEPTH without loss.
- At FULL, assert out_ready and in_valid together -> the pop occurs, there is no push that cycle, count=3; the next cycle in_ready=1 and the push is accepted.
- With 3 entries queued, assert flush together with in_valid -> next cycle count=0, out_valid=0, demux_in=0, in_ready=1; the flushed entries and that cycle's push never appear.
- With 2 entries queued, assert rst for 1 cycle -> count=0, out_valid=0, in_ready=0 during rst; in_ready=1 the following cycle.

Source files
------------

// File: rtl/demux_feed_stage.sv
// ----------------------------------------------------------------------------
// demux_feed_stage
//
// Purpose:
//   In-order buffer stage feeding the 1-to-2 result demux of the 8-bit
//   pipeline processor. Each ALU/writeback result arrives with a one-bit route
//   select through a valid/ready handshake. Results are queued in a small FIFO.
//   The head entry is presented as demux data/select, so consumer back-pressure
//   never drops a result. When the queue is empty, both demux_in and demux_s0
//   are driven to zero, so both demux outputs read zero on idle cycles.
//
// Ports:
//   clk        rising-edge clock for all state
//   rst        synchronous, active-high reset (priority over flush)
//   flush      synchronous clear of all queued entries
//   in_valid   upstream result valid
//   in_ready   stage can accept a result this cycle
//   in_data    result value [WIDTH]
//   in_sel     route select (1 = data_out1 path, 0 = data_out2 path)
//   out_valid  head entry on demux_in/demux_s0 is valid
//   out_ready  consumer accepts the head entry this cycle
//   demux_in   head data, 0 when out_valid = 0 [WIDTH]
//   demux_s0   head select, 0 when out_valid = 0
//   count      number of entries held [$clog2(DEPTH)+1]
//
// DEPTH must be a power of two and at least 2. The pointers wrap by natural
// binary overflow.
// ----------------------------------------------------------------------------
module demux_feed_stage #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic                   in_sel,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       demux_in,
    output logic                   demux_s0,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

    // Status states, registered alongside count
    localparam logic [1:0] ST_EMPTY   = 2'd0;
    localparam logic [1:0] ST_PARTIAL = 2'd1;
    localparam logic [1:0] ST_FULL    = 2'd2;

    // Storage: {sel, data} per entry; contents are never reset
    logic [WIDTH:0]       r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [CNT_W-1:0]     r_count;
    logic [1:0]           r_state;

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic [CNT_W-1:0]     w_count_nxt;
    logic [1:0]           w_state_nxt;
    logic [WIDTH:0]       w_head;

    // ------------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------------
    // in_ready drops combinationally while rst is held, so no result can be
    // accepted during a reset cycle. It recovers on the first cycle after rst
    // deasserts because the state is EMPTY by then.
    assign w_full    = (r_state == ST_FULL);
    assign in_ready  = ~rst & ~w_full;
    assign out_valid = (r_state != ST_EMPTY);

    assign w_push = in_valid & in_ready;
    assign w_pop  = out_valid & out_ready;

    // ------------------------------------------------------------------------
    // Next count / next status
    // ------------------------------------------------------------------------
    always_comb begin
        w_count_nxt = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_nxt = r_count + ONE_CNT;
            2'b01:   w_count_nxt = r_count - ONE_CNT;
            default: w_count_nxt = r_count;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                // A pop is impossible here, because out_valid = 0.
                if (w_push) begin
                    w_state_nxt = ST_PARTIAL;
                end
            end
            ST_PARTIAL: begin
                if (w_push && !w_pop && (r_count == LAST_CNT)) begin
                    w_state_nxt = ST_FULL;
                end else if (w_pop && !w_push && (r_count == ONE_CNT)) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                // A push is impossible here, because in_ready = 0.
                // There is no same-cycle passthrough when full.
                if (w_pop) begin
                    w_state_nxt = ST_PARTIAL;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // ------------------------------------------------------------------------
    // Control registers: rst outranks flush, and both outrank push/pop
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_state  <= ST_EMPTY;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Data array: written only on a real push
    // ------------------------------------------------------------------------
    // During a flush, the write is suppressed so the entry slot is left
    // untouched. This is harmless either way, since the pointers clear.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= {in_sel, in_data};
        end
    end

    // ------------------------------------------------------------------------
    // Head presentation, gated so idle cycles drive zero to the demux
    // ------------------------------------------------------------------------
    assign w_head   = r_mem[r_rd_ptr];
    assign demux_in = out_valid ? w_head[WIDTH-1:0] : '0;
    assign demux_s0 = out_valid & w_head[WIDTH];
    assign count    = r_count;

endmodule

// File: tb/tb_demux_feed_stage.sv
module tb_demux_feed_stage;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                   clk;
    logic                   rst;
    logic                   flush;
    logic                   in_valid;
    logic                   in_ready;
    logic [WIDTH-1:0]       in_data;
    logic                   in_sel;
    logic                   out_valid;
    logic                   out_ready;
    logic [WIDTH-1:0]       demux_in;
    logic                   demux_s0;
    logic [$clog2(DEPTH):0] count;

    int n_checks;
    int n_fails;

    // Scoreboard of {sel, data}, in expected presentation order
    logic [WIDTH:0] sb [$];

    demux_feed_stage #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .demux_in  (demux_in),
        .demux_s0  (demux_s0),
        .count     (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    // One clock cycle. It is called just after a falling edge: it drives the
    // inputs, checks the DUT against the scoreboard, updates the model, then
    // advances to the next falling edge.
    task automatic cycle(input logic r, input logic fl, input logic iv,
                         input logic [WIDTH-1:0] d, input logic s, input logic ordy);
        logic [WIDTH:0] head;
        logic [WIDTH:0] popped;
        logic           exp_rdy;
        rst       = r;
        flush     = fl;
        in_valid  = iv;
        in_data   = d;
        in_sel    = s;
        out_ready = ordy;
        #1;
        exp_rdy = !r && (sb.size() < DEPTH);
        head    = (sb.size() != 0) ? sb[0] : '0;
        chk("in_ready",  in_ready,  exp_rdy);
        chk("out_valid", out_valid, (sb.size() != 0));
        chk("count",     count,     sb.size());
        chk("demux_in",  demux_in,  head[WIDTH-1:0]);
        chk("demux_s0",  demux_s0,  head[WIDTH]);
        if (r || fl) begin
            sb.delete();
        end else begin
            if (sb.size() != 0 && ordy) begin
                popped = sb.pop_front();
                chk("pop_entry", {demux_s0, demux_in}, popped);
            end
            if (exp_rdy && iv) begin
                sb.push_back({s, d});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input logic ordy);
        cycle(1'b0, 1'b0, 1'b0, '0, 1'b0, ordy);
    endtask

    task automatic push(input logic [WIDTH-1:0] d, input logic s);
        cycle(1'b0, 1'b0, 1'b1, d, s, 1'b0);
    endtask

    initial begin
        logic [WIDTH-1:0] seq_d [4];
        logic             seq_s [4];
        n_checks  = 0;
        n_fails   = 0;
        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        // Reset state while rst is still held
        cycle(1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);

        // Idle shows zero, then a single push is presented next cycle
        idle(1'b0);
        push(8'hA5, 1'b1);
        idle(1'b0);
        idle(1'b1);
        idle(1'b0);

        // Fill to FULL, rejected fifth push, then drain in order
        seq_d[0] = 8'h11; seq_d[1] = 8'h22; seq_d[2] = 8'h33; seq_d[3] = 8'h44;
        seq_s[0] = 1'b0;  seq_s[1] = 1'b1;  seq_s[2] = 1'b0;  seq_s[3] = 1'b1;
        for (int i = 0; i < 4; i++) push(seq_d[i], seq_s[i]);
        push(8'h55, 1'b1);
        for (int i = 0; i < 4; i++) idle(1'b1);
        idle(1'b0);

        // Simultaneous push/pop at count 2, wrapping the pointers
        push(8'h01, 1'b0);
        push(8'h02, 1'b1);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 1'b1, WIDTH'(8'h10 + i), i[0], 1'b1);
        end
        idle(1'b1);
        idle(1'b1);
        idle(1'b0);

        // FULL with in_valid and out_ready together: pop only, then push
        for (int i = 0; i < 4; i++) push(WIDTH'(8'h60 + i), i[0]);
        cycle(1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b1, 8'h66, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) idle(1'b1);
        idle(1'b0);

        // Flush with a concurrent push
        for (int i = 0; i < 3; i++) push(WIDTH'(8'h70 + i), 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 8'h77, 1'b1, 1'b0);
        idle(1'b0);
        push(8'h78, 1'b0);
        idle(1'b1);
        idle(1'b0);

        // Mid-stream reset with push and pop requested
        push(8'h90, 1'b1);
        push(8'h91, 1'b0);
        cycle(1'b1, 1'b0, 1'b1, 8'h99, 1'b1, 1'b1);
        idle(1'b0);
        push(8'h9A, 1'b1);
        idle(1'b1);
        idle(1'b0);

        // Random traffic with occasional flush/reset
        for (int i = 0; i < 300; i++) begin
            cycle(($urandom_range(0, 49) == 0), ($urandom_range(0, 24) == 0),
                  1'($urandom_range(0, 1)), WIDTH'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < DEPTH + 1; i++) idle(1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
